dot_prod_seq: RTL and testbench



---
 rtl/dot_prod_pkg.sv | 21 ++
 rtl/dot_prod_seq_if.sv | 37 +++
 rtl/dot_prod_seq_sat_round.sv | 28 ++
 rtl/dot_prod_seq.sv | 100 ++++++++++
 tb/tb_dot_prod_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_prod_pkg.sv
// Shared types and default widths for the signed 8-bit dot-product sequencer.
package dot_prod_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 26;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 10;
  localparam int DEF_SHIFT  = 7;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ROUND,
    HOLD
  } state_t;

endpackage

// File: rtl/dot_prod_seq_if.sv
// Operand-memory, control and result handshake bundle for dot_prod_seq.
interface dot_prod_seq_if
  import dot_prod_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic                     start;
  logic                     abort;
  logic        [LEN_W-1:0]  len;
  logic        [ADDR_W-1:0] base_a;
  logic        [ADDR_W-1:0] base_b;
  logic                     re;
  logic        [ADDR_W-1:0] addr_a;
  logic        [ADDR_W-1:0] addr_b;
  logic signed [DATA_W-1:0] rdata_a;
  logic signed [DATA_W-1:0] rdata_b;
  logic                     busy;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [DATA_W-1:0] res_data;
  logic signed [ACC_W-1:0]  acc_out;

  modport master (
    output start, abort, len, base_a, base_b, rdata_a, rdata_b, res_ready,
    input  re, addr_a, addr_b, busy, res_valid, res_data, acc_out
  );

  modport slave (
    input  start, abort, len, base_a, base_b, rdata_a, rdata_b, res_ready,
    output re, addr_a, addr_b, busy, res_valid, res_data, acc_out
  );

endinterface

// File: rtl/dot_prod_seq_sat_round.sv
// Combinational requantizer: round-half-up arithmetic right shift, then saturate.
module sat_round
  import dot_prod_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);

  // Extra guard bit keeps the rounding add from wrapping near the accumulator limits.
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] HI  = (ACC_W+1)'(SAT_MAX);
  localparam logic signed [ACC_W:0] LO  = (ACC_W+1)'(SAT_MIN);

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = ($signed({a[ACC_W-1], a}) + RND) >>> SHIFT;
    if (r > HI)      round_sat = DATA_W'(HI);
    else if (r < LO) round_sat = DATA_W'(LO);
    else             round_sat = DATA_W'(r);
  endfunction

  assign res = round_sat(acc);

endmodule

// File: rtl/dot_prod_seq.sv
// Sequencer + MAC datapath: streams len operand pairs from A/B memories, accumulates, requantizes.
module dot_prod_seq
  import dot_prod_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input logic          clk,
  input logic          rst_n,
  dot_prod_seq_if.slave bus
);

  state_t                    state_q, state_d;
  logic        [LEN_W-1:0]   len_q;
  logic        [LEN_W-1:0]   cnt_q;
  logic        [ADDR_W-1:0]  base_a_q;
  logic        [ADDR_W-1:0]  base_b_q;
  logic                      last_issue;
  logic                      vld_p1;
  logic signed [2*DATA_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]   prod_ext_p1;
  logic signed [ACC_W-1:0]   acc_p2;
  logic signed [DATA_W-1:0]  sat_p2;
  logic signed [DATA_W-1:0]  res_p3;

  assign last_issue = (cnt_q == len_q - LEN_W'(1));

  // Stage p0: address issue while fetching
  assign bus.re     = (state_q == FETCH);
  assign bus.addr_a = base_a_q + ADDR_W'(cnt_q);
  assign bus.addr_b = base_b_q + ADDR_W'(cnt_q);

  // Stage p1: read data returns one cycle after re; form the signed product
  assign prod_p1     = bus.rdata_a * bus.rdata_b;
  assign prod_ext_p1 = $signed({{(ACC_W-2*DATA_W){prod_p1[2*DATA_W-1]}}, prod_p1});

  // Stage p2: accumulator feeds the requantizer
  sat_round #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_sat_round (
    .acc(acc_p2),
    .res(sat_p2)
  );

  // Stage p3: registered result
  assign bus.res_data  = res_p3;
  assign bus.acc_out   = acc_p2;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!bus.abort && bus.start) state_d = (bus.len == '0) ? ROUND : FETCH;
      FETCH: if (bus.abort) state_d = IDLE;
             else if (last_issue) state_d = DRAIN;
      DRAIN: state_d = bus.abort ? IDLE : ROUND;
      ROUND: state_d = bus.abort ? IDLE : HOLD;
      HOLD:  if (bus.abort || bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      vld_p1   <= 1'b0;
      acc_p2   <= '0;
      res_p3   <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= (state_q == FETCH) && !bus.abort;

      // An abort discards the in-flight read rather than folding it in.
      if (vld_p1 && !bus.abort) acc_p2 <= acc_p2 + prod_ext_p1;

      if (state_q == IDLE && bus.start && !bus.abort) begin
        len_q    <= bus.len;
        base_a_q <= bus.base_a;
        base_b_q <= bus.base_b;
        cnt_q    <= '0;
        acc_p2   <= '0;
      end

      if (state_q == FETCH && !bus.abort) cnt_q <= cnt_q + LEN_W'(1);

      if (state_q == ROUND && !bus.abort) res_p3 <= sat_p2;
    end
  end

endmodule

// File: tb/tb_dot_prod_seq.sv
// Directed + randomized bench for dot_prod_seq with a plain-arithmetic reference model.
module tb_dot_prod_seq;

  localparam int DW   = 8;
  localparam int AW   = 26;
  localparam int ADW  = 10;
  localparam int LW   = 10;
  localparam int SH   = 7;
  localparam int MEMD = 1 << ADW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_prod_seq_if #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW), .LEN_W(LW)) bus ();

  dot_prod_seq #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW), .LEN_W(LW), .SHIFT(SH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic signed [DW-1:0] mem_a [MEMD];
  logic signed [DW-1:0] mem_b [MEMD];

  always @(posedge clk) begin
    if (bus.re === 1'b1) begin
      bus.rdata_a <= mem_a[bus.addr_a];
      bus.rdata_b <= mem_b[bus.addr_b];
    end
  end

  int checks = 0;
  int failures = 0;
  int exp_acc_g;
  int exp_res_g;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int ba, input int bb, input int i, input int a, input int b);
    mem_a[(ba + i) % MEMD] = DW'(a);
    mem_b[(bb + i) % MEMD] = DW'(b);
  endtask

  function automatic int ref_dot(input int n, input int ba, input int bb);
    int s = 0;
    for (int i = 0; i < n; i++)
      s += int'(mem_a[(ba + i) % MEMD]) * int'(mem_b[(bb + i) % MEMD]);
    return s;
  endfunction

  // Round half up by floor division, then clamp to the signed 8-bit range.
  function automatic int ref_req(input int acc);
    int num, q, d;
    d = 1 << SH;
    num = acc + (d / 2);
    if (num >= 0) q = num / d;
    else q = -((-num + d - 1) / d);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op and wait for the result; leaves the DUT in HOLD without handshaking.
  task automatic do_op(input string tag, input int n, input int ba, input int bb);
    int e, re_cnt;
    exp_acc_g = ref_dot(n, ba, bb);
    exp_res_g = ref_req(exp_acc_g);
    bus.len    = LW'(n);
    bus.base_a = ADW'(ba);
    bus.base_b = ADW'(bb);
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    e = 0;
    re_cnt = 0;
    while (bus.res_valid !== 1'b1 && e < 100) begin
      if (bus.re === 1'b1) begin
        chk({tag, "_addr_a"}, longint'(bus.addr_a), longint'((ba + re_cnt) % MEMD));
        chk({tag, "_addr_b"}, longint'(bus.addr_b), longint'((bb + re_cnt) % MEMD));
        re_cnt++;
      end
      tick();
      e++;
    end
    chk({tag, "_latency"}, longint'(e), longint'((n == 0) ? 1 : n + 2));
    chk({tag, "_re_cycles"}, longint'(re_cnt), longint'(n));
    chk({tag, "_acc"}, longint'(bus.acc_out), longint'(exp_acc_g));
    chk({tag, "_res"}, longint'(bus.res_data), longint'(exp_res_g));
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_valid_drop"}, longint'(bus.res_valid), 0);
    chk({tag, "_idle"}, longint'(bus.busy), 0);
    chk({tag, "_acc_kept"}, longint'(bus.acc_out), longint'(exp_acc_g));
  endtask

  initial begin
    int a0b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.len = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < MEMD; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    repeat (3) tick();
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_re", longint'(bus.re), 0);
    chk("rst_valid", longint'(bus.res_valid), 0);
    chk("rst_res", longint'(bus.res_data), 0);
    chk("rst_acc", longint'(bus.acc_out), 0);
    chk("rst_addr", longint'(bus.addr_a), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) put(0, 0, i, i + 1, i + 5);
    do_op("basic", 4, 0, 0);
    chk("basic_acc_const", longint'(bus.acc_out), 70);
    chk("basic_res_const", longint'(bus.res_data), 1);
    handshake("basic");

    for (int i = 0; i < 3; i++) put(40, 50, i, 64, 1);
    do_op("rnd_up", 3, 40, 50);
    chk("rnd_up_const", longint'(bus.res_data), 2);
    handshake("rnd_up");
    put(40, 50, 2, 63, 1);
    do_op("rnd_dn", 3, 40, 50);
    chk("rnd_dn_const", longint'(bus.res_data), 1);
    handshake("rnd_dn");

    for (int i = 0; i < 4; i++) put(200, 300, i, -128, -128);
    do_op("sat_pos", 4, 200, 300);
    chk("sat_pos_const", longint'(bus.res_data), 127);
    handshake("sat_pos");
    for (int i = 0; i < 4; i++) put(200, 300, i, -128, 127);
    do_op("sat_neg", 4, 200, 300);
    chk("sat_neg_const", longint'(bus.res_data), -128);
    handshake("sat_neg");

    do_op("len0", 0, 0, 0);
    handshake("len0");

    // Back-pressure: result must hold and start must be ignored while in HOLD.
    for (int i = 0; i < 5; i++) put(500, 600, i, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    do_op("bp", 5, 500, 600);
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 2);
      bus.len = LW'(3);
      tick();
      chk("bp_valid_hold", longint'(bus.res_valid), 1);
      chk("bp_res_hold", longint'(bus.res_data), longint'(exp_res_g));
      chk("bp_no_re", longint'(bus.re), 0);
    end
    bus.start = 1'b0;
    handshake("bp");
    tick();
    chk("bp_no_late_start", longint'(bus.busy), 0);

    // Abort in IDLE beats start.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.len = LW'(4);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_idle_busy", longint'(bus.busy), 0);

    // Abort during the third FETCH cycle of an 8-long op.
    for (int i = 0; i < 8; i++) put(100, 900, i, $urandom_range(1, 127), $urandom_range(1, 127));
    a0b0 = int'(mem_a[100]) * int'(mem_b[900]);
    bus.len = LW'(8);
    bus.base_a = ADW'(100);
    bus.base_b = ADW'(900);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("abort_in_fetch", longint'(bus.re), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_re", longint'(bus.re), 0);
    chk("abort_valid", longint'(bus.res_valid), 0);
    chk("abort_acc", longint'(bus.acc_out), longint'(a0b0));
    repeat (3) begin
      tick();
      chk("abort_no_valid", longint'(bus.res_valid), 0);
    end
    for (int i = 0; i < 2; i++) put(10, 20, i, 3, 2);
    do_op("post_abort", 2, 10, 20);
    chk("post_abort_acc_const", longint'(bus.acc_out), 12);
    handshake("post_abort");

    // Randomized ops, back to back, including address wrap-around.
    for (int t = 0; t < 8; t++) begin
      int n, ba, bb, mag;
      n = $urandom_range(1, 24);
      ba = (t == 0) ? MEMD - 3 : $urandom_range(0, MEMD - 1);
      bb = (t == 1) ? MEMD - 5 : $urandom_range(0, MEMD - 1);
      mag = (t % 2 == 0) ? 16 : 128;
      for (int i = 0; i < n; i++)
        put(ba, bb, i, $urandom_range(0, 2 * mag - 1) - mag, $urandom_range(0, 2 * mag - 1) - mag);
      do_op("rand", n, ba, bb);
      handshake("rand");
    end

    // Reset in the middle of FETCH returns everything to zero.
    for (int i = 0; i < 8; i++) put(5, 5, i, 100, 100);
    bus.len = LW'(8);
    bus.base_a = ADW'(5);
    bus.base_b = ADW'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_re", longint'(bus.re), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_valid", longint'(bus.res_valid), 0);
    chk("midrst_res", longint'(bus.res_data), 0);
    chk("midrst_acc", longint'(bus.acc_out), 0);
    chk("midrst_addr_a", longint'(bus.addr_a), 0);
    chk("midrst_addr_b", longint'(bus.addr_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("post_rst", 8, 5, 5);
    handshake("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
